// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 Hz timing constants, the output bundle
// carried through the sync pipeline, and a small window-compare helper.
package vga_timing_pkg;

    localparam int VGA_CW    = 16;   // width of the H/V count buses
    localparam int VGA_PIX_W = 10;   // width of pixel_x / pixel_y

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam logic VGA_SYNC_POL = 1'b0;  // active-low sync pulses

    // Everything that travels through the delay line, decoded in stage 1.
    typedef struct packed {
        logic                 hsync;
        logic                 vsync;
        logic                 video_on;
        logic [VGA_PIX_W-1:0] pixel_x;
        logic [VGA_PIX_W-1:0] pixel_y;
        logic                 line_start;
        logic                 frame_start;
        logic [VGA_CW-1:0]    frame_count;
        logic                 timing_error;
    } sync_bundle_t;

    // Inclusive window compare on a count value.
    function automatic logic in_window(input logic [VGA_CW-1:0] x,
                                       input logic [VGA_CW-1:0] lo,
                                       input logic [VGA_CW-1:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// vga_pipe_delay: DEPTH-stage shift register of a WIDTH-bit word.
// Every stage resets asynchronously to RESET_VALUE so the whole line shows
// the idle pattern the moment rst_n drops. DEPTH must be >= 1.
// Ports:
//   clk_25MHz  pixel clock
//   rst_n      asynchronous active-low reset
//   d          word entering the line
//   q          word delayed by DEPTH clocks
module vga_pipe_delay #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_25MHz,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {DEPTH{RESET_VALUE}};
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: decodes the horizontal/vertical pixel counts into
// registered sync, blanking, pixel coordinates, line/frame strobes, a frame
// counter and a sticky counter-sequencing fault flag. All outputs share one
// latency of PIPE_DELAY clocks (1..4) to line up with the renderer.
// Ports:
//   clk_25MHz      pixel clock
//   rst_n          asynchronous active-low reset
//   H_count_Value  horizontal count, 0..H_TOTAL-1
//   V_count_Value  vertical count, 0..V_TOTAL-1
//   hsync, vsync   sync pulses, asserted level = SYNC_POL
//   video_on       inside the active window
//   pixel_x/y      coordinates inside the window, 0 outside
//   line_start     one clock at H==0
//   frame_start    one clock at H==0 && V==0
//   frame_count    frames started since reset (wraps)
//   timing_error   sticky fault flag, cleared only by reset
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = VGA_H_ACTIVE,
    parameter int   H_FP       = VGA_H_FP,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_TOTAL    = VGA_H_TOTAL,
    parameter int   V_ACTIVE   = VGA_V_ACTIVE,
    parameter int   V_FP       = VGA_V_FP,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_TOTAL    = VGA_V_TOTAL,
    parameter logic SYNC_POL   = VGA_SYNC_POL,
    parameter int   PIPE_DELAY = 2
) (
    input  logic                 clk_25MHz,
    input  logic                 rst_n,
    input  logic [VGA_CW-1:0]    H_count_Value,
    input  logic [VGA_CW-1:0]    V_count_Value,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic [VGA_PIX_W-1:0] pixel_x,
    output logic [VGA_PIX_W-1:0] pixel_y,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [VGA_CW-1:0]    frame_count,
    output logic                 timing_error
);

    localparam logic [VGA_CW-1:0] HA    = VGA_CW'(H_ACTIVE);
    localparam logic [VGA_CW-1:0] HS0   = VGA_CW'(H_ACTIVE + H_FP);
    localparam logic [VGA_CW-1:0] HS1   = VGA_CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VGA_CW-1:0] HT    = VGA_CW'(H_TOTAL);
    localparam logic [VGA_CW-1:0] HLAST = VGA_CW'(H_TOTAL - 1);
    localparam logic [VGA_CW-1:0] VA    = VGA_CW'(V_ACTIVE);
    localparam logic [VGA_CW-1:0] VS0   = VGA_CW'(V_ACTIVE + V_FP);
    localparam logic [VGA_CW-1:0] VS1   = VGA_CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VGA_CW-1:0] VT    = VGA_CW'(V_TOTAL);
    localparam logic [VGA_CW-1:0] VLAST = VGA_CW'(V_TOTAL - 1);
    localparam logic [VGA_CW-1:0] ONE   = VGA_CW'(1);
    localparam logic [VGA_CW-1:0] ZERO  = '0;

    localparam sync_bundle_t RST_B = '{
        hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b0,
        pixel_x: '0, pixel_y: '0, line_start: 1'b0, frame_start: 1'b0,
        frame_count: '0, timing_error: 1'b0
    };

    sync_bundle_t      s1_d, s1_q, out_b;
    logic [VGA_CW-1:0] prev_h, prev_v;
    logic              prev_valid;
    logic              active, frame_hit, h_wrap, v_step_ok, fault;

    // Stage-1 decode plus sequencing check on the raw counts.
    always_comb begin
        active    = (H_count_Value < HA) && (V_count_Value < VA);
        frame_hit = (H_count_Value == ZERO) && (V_count_Value == ZERO);
        h_wrap    = (prev_h == HLAST) && (H_count_Value == ZERO);
        v_step_ok = (V_count_Value == prev_v + ONE) ||
                    ((prev_v == VLAST) && (V_count_Value == ZERO));

        // Range faults are meaningful even before a previous sample exists.
        fault = (H_count_Value >= HT) || (V_count_Value >= VT);
        if (prev_valid) begin
            if ((H_count_Value != prev_h + ONE) && !h_wrap) fault = 1'b1;
            if ((H_count_Value != ZERO) && (V_count_Value != prev_v)) fault = 1'b1;
            // At a line wrap V must step (also catches a missed advance).
            if ((H_count_Value == ZERO) && !v_step_ok) fault = 1'b1;
        end

        s1_d              = RST_B;
        s1_d.hsync        = in_window(H_count_Value, HS0, HS1) ? SYNC_POL : ~SYNC_POL;
        s1_d.vsync        = in_window(V_count_Value, VS0, VS1) ? SYNC_POL : ~SYNC_POL;
        s1_d.video_on     = active;
        s1_d.pixel_x      = active ? H_count_Value[VGA_PIX_W-1:0] : '0;
        s1_d.pixel_y      = active ? V_count_Value[VGA_PIX_W-1:0] : '0;
        s1_d.line_start   = (H_count_Value == ZERO);
        s1_d.frame_start  = frame_hit;
        // The stage-1 register is the frame counter itself, so the new count
        // rides alongside its frame_start strobe.
        s1_d.frame_count  = s1_q.frame_count + {{(VGA_CW-1){1'b0}}, frame_hit};
        s1_d.timing_error = s1_q.timing_error | fault;
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= RST_B;
            prev_h     <= '0;
            prev_v     <= '0;
            prev_valid <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            prev_h     <= H_count_Value;
            prev_v     <= V_count_Value;
            prev_valid <= 1'b1;
        end
    end

    generate
        if (PIPE_DELAY <= 1) begin : g_direct
            assign out_b = s1_q;
        end else begin : g_delay
            vga_pipe_delay #(
                .WIDTH      ($bits(sync_bundle_t)),
                .DEPTH      (PIPE_DELAY - 1),
                .RESET_VALUE(RST_B)
            ) u_delay (
                .clk_25MHz(clk_25MHz),
                .rst_n    (rst_n),
                .d        (s1_q),
                .q        (out_b)
            );
        end
    endgenerate

    assign hsync        = out_b.hsync;
    assign vsync        = out_b.vsync;
    assign video_on     = out_b.video_on;
    assign pixel_x      = out_b.pixel_x;
    assign pixel_y      = out_b.pixel_y;
    assign line_start   = out_b.line_start;
    assign frame_start  = out_b.frame_start;
    assign frame_count  = out_b.frame_count;
    assign timing_error = out_b.timing_error;

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
- Downstream consumer of the horizontal and vertical pixel counters in the 640x480@60 Hz VGA path of the oscilloscope display.
- Decodes H_count_Value/V_count_Value into registered hsync, vsync, video_on, pixel coordinates, line/frame strobes and a frame counter.
- Delays all outputs by a programmable pipeline depth to align with the sample-RAM/renderer read latency.
- Flags counter sequencing faults with a sticky error bit.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_TOTAL, 525, lines per frame
- SYNC_POL, 0, sync pulse level (0 = active-low pulses)
- PIPE_DELAY, 2, total output latency in clocks; legal range 1..4

Ports:
- clk_25MHz  input  1  pixel clock
- rst_n  input  1  asynchronous, active-low reset
- H_count_Value  input  16  horizontal count, 0..H_TOTAL-1
- V_count_Value  input  16  vertical count, 0..V_TOTAL-1; advances when H wraps to 0
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- video_on  output  1  high inside the active 640x480 window
- pixel_x  output  10  H count when video_on, else 0
- pixel_y  output  10  V count when video_on, else 0
- line_start  output  1  one-clock pulse for H==0
- frame_start  output  1  one-clock pulse for H==0 && V==0
- frame_count  output  16  frames started since reset
- timing_error  output  1  sticky counter-fault flag

Behaviour:
- Clock and reset: one clock, clk_25MHz; rst_n is asynchronous, active-low.
- Reset values (every pipeline stage and every output):
  - hsync = vsync = ~SYNC_POL (inactive level).
  - video_on, pixel_x, pixel_y, line_start, frame_start, frame_count and timing_error all 0.
- Stage 1 (registered decode of the current inputs):
  - video_on = (H < H_ACTIVE) && (V < V_ACTIVE).
  - Horizontal pulse: H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751. hsync = SYNC_POL inside the pulse, ~SYNC_POL outside.
  - Vertical pulse: V in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, applied to vsync the same way.
  - pixel_x/pixel_y: the low 10 bits of H/V, forced to 0 outside the active window.
- Stages 2..PIPE_DELAY: plain shift register of the full decoded bundle. Output at cycle n reflects the inputs sampled at cycle n-PIPE_DELAY. PIPE_DELAY=1 means stage 1 drives the outputs directly.
- frame_count:
  - Increments in stage 1 whenever it asserts frame_start; wraps 0xFFFF->0.
  - Travels through the pipeline with the other fields, so it updates in the same output cycle as frame_start.
- Sequencing checker (runs on the raw inputs, stage-1 timing):
  - Holds prev_H, prev_V and a prev_valid bit; prev_valid is cleared by reset and set after the first sampled cycle.
  - With prev_valid=1, a fault is any of the following:
    - H >= H_TOTAL, or V >= V_TOTAL.
    - H != prev_H+1, except the legal wrap prev_H==H_TOTAL-1 && H==0.
    - V changes while H != 0.
    - At an H wrap, V is neither prev_V+1 nor the legal wrap (prev_V==V_TOTAL-1 && V==0).
    - At an H wrap, V == prev_V (missed vertical advance).
  - Range faults (H >= H_TOTAL, V >= V_TOTAL) are also checked on the first cycle after reset.
  - A fault sets timing_error; it stays set until reset. It passes through the same delay as the other outputs.
- Out-of-range inputs: decode still uses the raw values. video_on = 0, pixel_x/pixel_y = 0, and sync follows the range compares (normally inactive).
- Reset mid-frame: all stages clear at once and the outputs take their idle values immediately. After release, the first valid frame_start occurs at the next H==0/V==0. No fault is reported for the discontinuity, because prev_valid is 0.

Decomposition:
- Shared package vga_timing_pkg holds the 640x480 timing constants (H_ACTIVE..V_TOTAL, sync start/end), the SYNC_POL default and a count width of 16. vertical_counter and the horizontal counter share these constants.
- One sub-module is natural: vga_pipe_delay, a parameterised (WIDTH, DEPTH) shift register with asynchronous active-low reset to a per-bit RESET_VALUE vector. It implements stages 2..PIPE_DELAY.

Test Plan:
- Nominal run:
  - Stimulus: drive legal counts for 2 full frames with PIPE_DELAY=2.
  - Required: video_on high for exactly 307200 clocks per frame; hsync low for clocks 656..751 of every line; vsync low on lines 490..491; timing_error stays 0.
- Latency:
  - Stimulus: PIPE_DELAY=1, then PIPE_DELAY=3; inputs at H=639,V=0 then H=640,V=0.
  - Required: video_on falls exactly 1 (resp. 3) clocks after H=640 is presented, and pixel_x shows 639 on the preceding cycle.
- Frame strobes:
  - Stimulus: start the counters at H=798,V=524, then run.
  - Required: line_start and frame_start pulse together for exactly one clock; frame_count goes 0->1; frame_count preloaded near 0xFFFF wraps 0xFFFF->0.
- Horizontal sequencing fault:
  - Stimulus: inject H=100 followed by H=102.
  - Required: timing_error rises PIPE_DELAY clocks later and stays 1 through subsequent legal frames.
- Range fault:
  - Stimulus: inject V=525 with H=0 immediately after reset release.
  - Required: timing_error set, video_on=0, pixel_y=0.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 asynchronously at H=300,V=200, then release.
  - Required: outputs immediately idle (hsync=vsync=1, video_on=0, frame_count=0); no timing_error after release; the next frame_start occurs at H=0,V=0.
